psum_accum_writer: RTL and testbench

- Sink-side counterpart of the convolution core's BRAM image reader.
- Receives the core's four 8-bit partial-sum lanes per output pixel and accumulates them over all input-channel groups in an internal scratch buffer.
- Requantises each accumulated output-channel group and writes it as packed 32-bit words into the output-feature-map BRAM.
- Sits between the multi-conv-core wrapper's psum outputs and the output BRAM port.

---
 rtl/psum_accum_writer_if.sv | 29 ++
 rtl/psum_accum_writer.sv | 200 ++++++++++++++++++++
 tb/tb_psum_accum_writer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accum_writer_if.sv
// rtl/psum_accum_writer_if.sv - psum stream and output BRAM bundle for psum_accum_writer
// Purpose: groups the partial-sum handshake and the output-BRAM write port.
// Signals:
//   psum_valid / psum_ready : partial-sum beat handshake
//   psum_0..psum_3          : signed 8-bit partial sums, lanes 0..3
//   bram_addr / bram_din    : output BRAM byte address and packed word
//   bram_we                 : byte write enables (4'hF or 0)
// Modports: master = psum producer / BRAM observer, slave = psum_accum_writer.
interface psum_accum_writer_if;
  logic        psum_valid;
  logic        psum_ready;
  logic [7:0]  psum_0;
  logic [7:0]  psum_1;
  logic [7:0]  psum_2;
  logic [7:0]  psum_3;
  logic [31:0] bram_addr;
  logic [31:0] bram_din;
  logic [3:0]  bram_we;

  modport master (
    output psum_valid, psum_0, psum_1, psum_2, psum_3,
    input  psum_ready, bram_addr, bram_din, bram_we
  );

  modport slave (
    input  psum_valid, psum_0, psum_1, psum_2, psum_3,
    output psum_ready, bram_addr, bram_din, bram_we
  );
endinterface

// File: rtl/psum_accum_writer.sv
// rtl/psum_accum_writer.sv - accumulates conv-core partial sums and writes requantised words to BRAM
// Purpose: sums four 8-bit psum lanes per pixel over all input-channel groups in a
// scratch buffer, then drains each output-channel group as packed 32-bit words.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   init_signal        : start pulse, latches channel_input_img / no_channel_out / WxW_out
//   channel_input_img  : input-channel groups to accumulate
//   no_channel_out     : output-channel groups
//   WxW_out            : output pixels per channel
//   bus (slave)        : psum handshake in, BRAM write port out
//   busy, done, err    : run in progress, completion pulse, sticky error
module psum_accum_writer #(
  parameter int          ACC_W    = 20,
  parameter int          MAX_PIX  = 1024,
  parameter int          SHIFT    = 0,
  parameter bit          RELU     = 1'b1,
  parameter logic [31:0] OUT_BASE = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_signal,
  input  logic [11:0]           channel_input_img,
  input  logic [10:0]           no_channel_out,
  input  logic [15:0]           WxW_out,
  psum_accum_writer_if.slave    bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PIX_AW = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FIN} state_t;

  state_t state, state_d;

  logic [11:0]          cfg_ch;
  logic [10:0]          cfg_oc;
  logic [15:0]          cfg_wxw;
  logic [15:0]          pix;        // pixel index while accumulating, word index while draining
  logic [11:0]          cg;
  logic [10:0]          og;
  logic [29:0]          out_word;   // running word offset from OUT_BASE across all groups
  logic                 started;
  logic [31:0]          addr_q;
  logic [31:0]          din_q;

  logic [4*ACC_W-1:0]   scratch [MAX_PIX];
  logic [4*ACC_W-1:0]   rd_word;
  logic [4*ACC_W-1:0]   wr_word;
  logic [ACC_W-1:0]     sx;
  logic [7:0]           lane_in [4];

  logic                 ready_c;
  logic                 accept;
  logic                 drop;
  logic                 drain_we;
  logic                 last_pix;
  logic                 last_cg;
  logic                 last_og;
  logic                 cfg_zero;
  logic                 cfg_big;
  logic [31:0]          drain_addr;
  logic [31:0]          drain_din;

  assign lane_in[0] = bus.psum_0;
  assign lane_in[1] = bus.psum_1;
  assign lane_in[2] = bus.psum_2;
  assign lane_in[3] = bus.psum_3;

  assign ready_c  = (state == ACCUM);
  assign drain_we = (state == DRAIN);
  assign accept   = bus.psum_valid & ready_c;
  // Beats offered while not ready are lost; before the first init nothing is expected.
  assign drop     = bus.psum_valid & ~ready_c & ((state != IDLE) | started);

  assign last_pix = (pix == cfg_wxw - 16'd1);
  assign last_cg  = (cg == cfg_ch - 12'd1);
  assign last_og  = (og == cfg_oc - 11'd1);
  assign cfg_zero = (channel_input_img == '0) | (no_channel_out == '0) | (WxW_out == '0);
  assign cfg_big  = (32'(WxW_out) > MAX_PIX);

  // Same scratch row serves the accumulate read and the drain read.
  assign rd_word    = scratch[pix[PIX_AW-1:0]];
  assign drain_addr = OUT_BASE + {out_word, 2'b00};

  function automatic logic [7:0] pack_lane(input logic [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] v;
    v = $signed(acc) >>> SHIFT;
    if (RELU && (v < 0)) v = '0;
    if (v > SAT_HI)      pack_lane = 8'h7f;
    else if (v < SAT_LO) pack_lane = 8'h80;
    else                 pack_lane = v[7:0];
  endfunction

  always_comb begin
    wr_word   = '0;
    drain_din = '0;
    sx        = '0;
    for (int n = 0; n < 4; n++) begin
      sx = {{(ACC_W-8){lane_in[n][7]}}, lane_in[n]};
      // The first input-channel group overwrites, so stale data from a previous group never leaks.
      wr_word[n*ACC_W +: ACC_W] = (cg == '0) ? sx : rd_word[n*ACC_W +: ACC_W] + sx;
      drain_din[8*n +: 8]       = pack_lane(rd_word[n*ACC_W +: ACC_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) scratch[pix[PIX_AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (init_signal) state_d = (cfg_zero | cfg_big) ? FIN : ACCUM;
      end
      ACCUM: begin
        if (accept && last_pix && last_cg) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_pix) state_d = last_og ? FIN : ACCUM;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ch   <= '0;
      cfg_oc   <= '0;
      cfg_wxw  <= '0;
      pix      <= '0;
      cg       <= '0;
      og       <= '0;
      out_word <= '0;
      started  <= 1'b0;
      err      <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      if (drop) err <= 1'b1;
      case (state)
        IDLE: begin
          if (init_signal) begin
            cfg_ch   <= channel_input_img;
            cfg_oc   <= no_channel_out;
            cfg_wxw  <= WxW_out;
            pix      <= '0;
            cg       <= '0;
            og       <= '0;
            out_word <= '0;
            started  <= 1'b1;
            err      <= cfg_big;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (last_pix) begin
              pix <= '0;
              cg  <= cg + 12'd1;
            end else begin
              pix <= pix + 16'd1;
            end
          end
        end
        DRAIN: begin
          addr_q   <= drain_addr;
          din_q    <= drain_din;
          out_word <= out_word + 30'd1;
          if (last_pix) begin
            pix <= '0;
            cg  <= '0;
            og  <= og + 11'd1;
          end else begin
            pix <= pix + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address and data are live during DRAIN and otherwise hold the last written word.
  assign bus.psum_ready = ready_c;
  assign bus.bram_we    = drain_we ? 4'hF : 4'h0;
  assign bus.bram_addr  = drain_we ? drain_addr : addr_q;
  assign bus.bram_din   = drain_we ? drain_din : din_q;
  assign busy           = (state == ACCUM) | (state == DRAIN);
  assign done           = (state == FIN);

endmodule

// File: tb/tb_psum_accum_writer.sv
// tb/tb_psum_accum_writer.sv - randomized self-checking bench for psum_accum_writer
module tb_psum_accum_writer;

  localparam int          ACC_W    = 20;
  localparam int          MAX_PIX  = 1024;
  localparam int          SHIFT    = 0;
  localparam bit          RELU     = 1'b1;
  localparam logic [31:0] OUT_BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_signal;
  logic [11:0] ch_in;
  logic [10:0] oc_in;
  logic [15:0] wxw_in;
  logic        busy, done, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  psum_accum_writer_if bus ();

  psum_accum_writer #(
    .ACC_W(ACC_W), .MAX_PIX(MAX_PIX), .SHIFT(SHIFT), .RELU(RELU), .OUT_BASE(OUT_BASE)
  ) dut (
    .clk(clk), .rst(rst), .init_signal(init_signal),
    .channel_input_img(ch_in), .no_channel_out(oc_in), .WxW_out(wxw_in),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] beats[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  int          acc_cyc[$];
  int          init_cyc;
  int          bad_we_cnt = 0;
  logic        timed_out;

  always @(negedge clk) begin
    if (bus.bram_we != 4'h0) begin
      wr_addr.push_back(bus.bram_addr);
      wr_data.push_back(bus.bram_din);
      wr_cyc.push_back(cyc);
      if (bus.bram_we != 4'hF) bad_we_cnt++;
    end
    if (done) done_cyc.push_back(cyc);
  end

  // Error-free result: per lane, sum the signed bytes of every input group for that pixel.
  function automatic void build_expected(input int ch, input int wxw, input int oc);
    logic [31:0] word, b;
    logic [7:0]  byte_v;
    int          s, v;
    exp_addr.delete();
    exp_data.delete();
    for (int og = 0; og < oc; og++) begin
      for (int k = 0; k < wxw; k++) begin
        word = '0;
        for (int n = 0; n < 4; n++) begin
          s = 0;
          for (int g = 0; g < ch; g++) begin
            b = beats[og*ch*wxw + g*wxw + k];
            byte_v = b[8*n +: 8];
            s += int'($signed(byte_v));
          end
          s = s & ((1 << ACC_W) - 1);
          if (s >= (1 << (ACC_W-1))) s -= (1 << ACC_W);
          v = s >>> SHIFT;
          if (RELU && v < 0) v = 0;
          if (v > 127) v = 127;
          if (v < -128) v = -128;
          word[8*n +: 8] = v[7:0];
        end
        exp_addr.push_back(OUT_BASE + 32'(4*(og*wxw + k)));
        exp_data.push_back(word);
      end
    end
  endfunction

  function automatic void gen_random(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back($urandom);
  endfunction

  // mode 0: back-to-back, 1: random gaps, 2: psum_valid held high throughout
  task automatic drive_run(input int ch, input int wxw, input int oc, input int mode, input int abort_at);
    int nbeats, i, guard;
    nbeats = (wxw > MAX_PIX) ? 0 : ch*wxw*oc;
    acc_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
    timed_out = 1'b0;
    ch_in = 12'(ch); oc_in = 11'(oc); wxw_in = 16'(wxw);
    init_signal = 1'b1;
    init_cyc = cyc;
    @(negedge clk);
    init_signal = 1'b0;
    i = 0;
    guard = 0;
    while (i < nbeats && guard < 20000) begin
      guard++;
      if (abort_at >= 0 && i == abort_at) begin
        bus.psum_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (mode == 1 && $urandom_range(0, 2) == 0) begin
        bus.psum_valid = 1'b0;
      end else if (bus.psum_ready || mode == 2) begin
        bus.psum_valid = 1'b1;
        {bus.psum_3, bus.psum_2, bus.psum_1, bus.psum_0} = beats[i];
        if (bus.psum_ready) begin
          acc_cyc.push_back(cyc);
          i++;
        end
      end else begin
        bus.psum_valid = 1'b0;
      end
      @(negedge clk);
    end
    if (i < nbeats) timed_out = 1'b1;
    if (mode == 2) {bus.psum_3, bus.psum_2, bus.psum_1, bus.psum_0} = $urandom;
    else bus.psum_valid = 1'b0;
    guard = 0;
    while (!done && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!done) timed_out = 1'b1;
    @(negedge clk);
    bus.psum_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    init_signal = 1'b0;
    ch_in = '0; oc_in = '0; wxw_in = '0;
    bus.psum_valid = 1'b0;
    {bus.psum_3, bus.psum_2, bus.psum_1, bus.psum_0} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (bus.psum_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.psum_ready); end
    total++; if (bus.bram_we !== 4'h0) begin bad++; $display("FAIL reset_we got=%h exp=0", bus.bram_we); end
    total++; if (bus.bram_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.bram_addr); end
    total++; if (bus.bram_din !== 32'h0) begin bad++; $display("FAIL reset_din got=%h exp=0", bus.bram_din); end
  endtask

  task automatic test_basic;
    beats.delete();
    for (int i = 0; i < 16; i++) beats.push_back(32'h01010101);
    drive_run(2, 4, 2, 0, -1);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
    total++; if (wr_data.size() !== 8) begin bad++; $display("FAIL basic_count got=%0d exp=8", wr_data.size()); end
    if (wr_data.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        total++; if (wr_addr[k] !== 32'(4*k)) begin bad++; $display("FAIL basic_addr[%0d] got=%h exp=%h", k, wr_addr[k], 4*k); end
        total++; if (wr_data[k] !== 32'h02020202) begin bad++; $display("FAIL basic_data[%0d] got=%h exp=02020202", k, wr_data[k]); end
      end
      total++; if (wr_cyc[0] !== acc_cyc[7] + 1) begin bad++; $display("FAIL basic_first_lat got=%0d exp=%0d", wr_cyc[0], acc_cyc[7] + 1); end
      total++; if (wr_cyc[4] !== acc_cyc[15] + 1) begin bad++; $display("FAIL basic_second_lat got=%0d exp=%0d", wr_cyc[4], acc_cyc[15] + 1); end
      total++; if (wr_cyc[3] !== wr_cyc[0] + 3) begin bad++; $display("FAIL basic_burst got=%0d exp=%0d", wr_cyc[3], wr_cyc[0] + 3); end
      total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cyc.size()); end
      else begin
        total++; if (done_cyc[0] !== wr_cyc[7] + 1) begin bad++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc[0], wr_cyc[7] + 1); end
      end
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_relu_sat;
    beats.delete();
    for (int i = 0; i < 8; i++) beats.push_back(32'h000064FB);
    drive_run(2, 4, 1, 0, -1);
    total++; if (wr_data.size() !== 4) begin bad++; $display("FAIL relu_count got=%0d exp=4", wr_data.size()); end
    if (wr_data.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        total++; if (wr_data[k] !== 32'h00007F00) begin bad++; $display("FAIL relu_data[%0d] got=%h exp=00007f00", k, wr_data[k]); end
      end
    end
  endtask

  task automatic test_hold_valid;
    gen_random(16);
    build_expected(2, 4, 2);
    drive_run(2, 4, 2, 2, -1);
    total++; if (wr_data.size() !== exp_data.size()) begin bad++; $display("FAIL hold_count got=%0d exp=%0d", wr_data.size(), exp_data.size()); end
    if (wr_data.size() == exp_data.size()) begin
      for (int k = 0; k < exp_data.size(); k++) begin
        total++; if (wr_data[k] !== exp_data[k] || wr_addr[k] !== exp_addr[k]) begin
          bad++; $display("FAIL hold_word[%0d] got=%h@%h exp=%h@%h", k, wr_data[k], wr_addr[k], exp_data[k], exp_addr[k]);
        end
      end
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL hold_err got=%b exp=1", err); end
    total++; if (acc_cyc.size() !== 16) begin bad++; $display("FAIL hold_accepts got=%0d exp=16", acc_cyc.size()); end
  endtask

  task automatic test_gaps;
    gen_random(16);
    build_expected(2, 4, 2);
    drive_run(2, 4, 2, 1, -1);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL gaps_timeout got=%b exp=0", timed_out); end
    total++; if (wr_data.size() !== exp_data.size()) begin bad++; $display("FAIL gaps_count got=%0d exp=%0d", wr_data.size(), exp_data.size()); end
    if (wr_data.size() == exp_data.size() && acc_cyc.size() == 16) begin
      for (int k = 0; k < exp_data.size(); k++) begin
        total++; if (wr_data[k] !== exp_data[k] || wr_addr[k] !== exp_addr[k]) begin
          bad++; $display("FAIL gaps_word[%0d] got=%h@%h exp=%h@%h", k, wr_data[k], wr_addr[k], exp_data[k], exp_addr[k]);
        end
      end
      total++; if (wr_cyc[0] !== acc_cyc[7] + 1) begin bad++; $display("FAIL gaps_first_lat got=%0d exp=%0d", wr_cyc[0], acc_cyc[7] + 1); end
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL gaps_err got=%b exp=0", err); end
  endtask

  task automatic test_rst_mid;
    gen_random(16);
    build_expected(2, 4, 2);
    drive_run(2, 4, 2, 0, 5);
    repeat (3) @(negedge clk);
    total++; if (wr_data.size() !== 0) begin bad++; $display("FAIL rst_no_writes got=%0d exp=0", wr_data.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (bus.psum_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.psum_ready); end
    drive_run(2, 4, 2, 0, -1);
    total++; if (wr_data.size() !== exp_data.size()) begin bad++; $display("FAIL rst_rerun_count got=%0d exp=%0d", wr_data.size(), exp_data.size()); end
    if (wr_data.size() == exp_data.size()) begin
      for (int k = 0; k < exp_data.size(); k++) begin
        total++; if (wr_data[k] !== exp_data[k] || wr_addr[k] !== exp_addr[k]) begin
          bad++; $display("FAIL rst_word[%0d] got=%h@%h exp=%h@%h", k, wr_data[k], wr_addr[k], exp_data[k], exp_addr[k]);
        end
      end
    end
  endtask

  task automatic test_degenerate;
    logic ok;
    beats.delete();
    drive_run(2, 0, 2, 0, -1);
    total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cyc.size()); end
    else begin
      ok = (done_cyc[0] >= init_cyc + 1) && (done_cyc[0] <= init_cyc + 2);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL zero_done_cyc got=%0d exp=%0d..%0d", done_cyc[0], init_cyc + 1, init_cyc + 2); end
    end
    total++; if (wr_data.size() !== 0) begin bad++; $display("FAIL zero_writes got=%0d exp=0", wr_data.size()); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL zero_err got=%b exp=0", err); end
    drive_run(1, MAX_PIX + 1, 1, 0, -1);
    total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL big_done_cnt got=%0d exp=1", done_cyc.size()); end
    total++; if (wr_data.size() !== 0) begin bad++; $display("FAIL big_writes got=%0d exp=0", wr_data.size()); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL big_err got=%b exp=1", err); end
  endtask

  task automatic test_random;
    int ch, wxw, oc, mode;
    for (int it = 0; it < 5; it++) begin
      ch   = $urandom_range(1, 3);
      wxw  = $urandom_range(1, 8);
      oc   = $urandom_range(1, 3);
      mode = $urandom_range(0, 1);
      gen_random(ch*wxw*oc);
      build_expected(ch, wxw, oc);
      drive_run(ch, wxw, oc, mode, -1);
      total++; if (wr_data.size() !== exp_data.size()) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, wr_data.size(), exp_data.size()); end
      if (wr_data.size() == exp_data.size()) begin
        for (int k = 0; k < exp_data.size(); k++) begin
          total++; if (wr_data[k] !== exp_data[k] || wr_addr[k] !== exp_addr[k]) begin
            bad++; $display("FAIL rand%0d_word[%0d] got=%h@%h exp=%h@%h", it, k, wr_data[k], wr_addr[k], exp_data[k], exp_addr[k]);
          end
        end
        if (done_cyc.size() == 1) begin
          total++; if (done_cyc[0] !== wr_cyc[wr_cyc.size()-1] + 1) begin bad++; $display("FAIL rand%0d_done got=%0d exp=%0d", it, done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1); end
        end else begin
          total++; bad++; $display("FAIL rand%0d_done_cnt got=%0d exp=1", it, done_cyc.size());
        end
      end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rand%0d_err got=%b exp=0", it, err); end
    end
    total++; if (bad_we_cnt !== 0) begin bad++; $display("FAIL we_pattern got=%0d exp=0", bad_we_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_sat();
    test_hold_valid();
    test_gaps();
    test_rst_mid();
    test_degenerate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
